// File: rtl/bus_timer_if.sv
// bus_timer_if -- request/grant bus between an LSU and a memory-mapped peripheral.
//
// Signals:
//   i_BUS_ADDR  [31:0]  byte address from the requester
//   i_BUS_WDATA [31:0]  write data, already placed in its byte lanes
//   i_BUS_WE            write strobe
//   i_BUS_RE            read strobe
//   i_BUS_HB    [1:0]   access size: 00 byte, 01 half, 1x word
//   i_BUS_REQ           request, held until the requester samples grant
//   o_BUS_GNT           completion grant
//   o_BUS_RDATA [31:0]  read data, zero whenever grant is low (bus is OR-combined)
//
// Modports: master (requester side), slave (peripheral side).
interface bus_timer_if;
    logic [31:0] i_BUS_ADDR;
    logic [31:0] i_BUS_WDATA;
    logic        i_BUS_WE;
    logic        i_BUS_RE;
    logic [1:0]  i_BUS_HB;
    logic        i_BUS_REQ;
    logic        o_BUS_GNT;
    logic [31:0] o_BUS_RDATA;

    modport master (
        output i_BUS_ADDR, i_BUS_WDATA, i_BUS_WE, i_BUS_RE, i_BUS_HB, i_BUS_REQ,
        input  o_BUS_GNT, o_BUS_RDATA
    );

    modport slave (
        input  i_BUS_ADDR, i_BUS_WDATA, i_BUS_WE, i_BUS_RE, i_BUS_HB, i_BUS_REQ,
        output o_BUS_GNT, o_BUS_RDATA
    );
endinterface

// File: rtl/bus_timer.sv
// bus_timer -- memory-mapped prescaled timer with compare match and level interrupt.
//
// Ports:
//   i_CLK   single clock, all state on its rising edge
//   i_RST   synchronous active-high reset
//   bus     bus_timer_if.slave register access port (2-cycle request/grant)
//   o_IRQ   level interrupt = MATCH & IRQ_EN, driven straight from a flop
//
// Register window (32 bytes at BASE_ADDR, offset = addr[4:2]):
//   0 CTRL     {AUTO_RELOAD, IRQ_EN, EN}
//   1 PRESCALE [15:0]
//   2 COUNT    [31:0]
//   3 COMPARE  [31:0]
//   4 STATUS   {MATCH}, write 1 to clear
//   5-7        read as zero, writes ignored
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    bus_timer_if.slave bus,
    output logic       o_IRQ
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;          // {AUTO_RELOAD, IRQ_EN, EN}
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        sel;
    logic        accept;
    logic        wr;
    logic [2:0]  offset;
    logic [3:0]  be;
    logic [31:0] wmask;
    logic [31:0] rd_val;
    logic [31:0] merged;
    logic        tick;

    assign offset = bus.i_BUS_ADDR[4:2];

    // Byte lane enables; an all-zero result means the access is misaligned
    // and the write is dropped (grant is still issued).
    always_comb begin
        be = 4'b0000;
        case (bus.i_BUS_HB)
            2'b00: be = 4'b0001 << bus.i_BUS_ADDR[1:0];
            2'b01: begin
                if (!bus.i_BUS_ADDR[0]) begin
                    be = bus.i_BUS_ADDR[1] ? 4'b1100 : 4'b0011;
                end
            end
            default: begin
                if (bus.i_BUS_ADDR[1:0] == 2'b00) begin
                    be = 4'b1111;
                end
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{be[gi]}};
        end
    endgenerate

    // Current register value at the addressed offset, unused bits zero.
    always_comb begin
        rd_val = 32'b0;
        case (offset)
            OFF_CTRL:     rd_val = {29'b0, ctrl_q};
            OFF_PRESCALE: rd_val = {16'b0, prescale_q};
            OFF_COUNT:    rd_val = count_q;
            OFF_COMPARE:  rd_val = compare_q;
            OFF_STATUS:   rd_val = {31'b0, match_q};
            default:      rd_val = 32'b0;
        endcase
    end

    // Partial writes merge into the current value; narrower registers simply
    // keep the low bits of the merge.
    assign merged = (rd_val & ~wmask) | (bus.i_BUS_WDATA & wmask);

    assign sel    = bus.i_BUS_REQ
                  && (bus.i_BUS_ADDR[31:5] == BASE_ADDR[31:5])
                  && (bus.i_BUS_WE || bus.i_BUS_RE);
    assign accept = (state_q == IDLE) && sel;
    assign wr     = accept && bus.i_BUS_WE && (be != 4'b0000);
    assign tick   = ctrl_q[0] && (pc_q == prescale_q);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        pc_d       = pc_q;
        rdata_d    = 32'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACK;
                    rdata_d = rd_val;   // pre-write value
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Timer datapath; bus writes below override it in the same cycle.
        if (ctrl_q[0]) begin
            pc_d = tick ? 16'd0 : pc_q + 16'd1;
        end
        if (tick) begin
            count_d = (count_q == compare_q && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
        end

        if (wr) begin
            case (offset)
                OFF_CTRL: ctrl_d = merged[2:0];
                OFF_PRESCALE: begin
                    prescale_d = merged[15:0];
                    pc_d       = 16'd0;
                end
                OFF_COUNT:   count_d   = merged;
                OFF_COMPARE: compare_d = merged;
                OFF_STATUS: begin
                    if (be[0] && bus.i_BUS_WDATA[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Set has priority over a simultaneous write-1-to-clear.
        if (tick && count_q == compare_q) begin
            match_d = 1'b1;
        end

        // Computed from next-state values so o_IRQ tracks MATCH & IRQ_EN
        // in the same cycle while still coming from a flop.
        irq_d = match_d & ctrl_d[1];
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= IDLE;
            ctrl_q     <= 3'b0;
            prescale_q <= 16'b0;
            count_q    <= 32'b0;
            compare_q  <= 32'b0;
            match_q    <= 1'b0;
            pc_q       <= 16'b0;
            rdata_q    <= 32'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            pc_q       <= pc_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.o_BUS_GNT   = (state_q == ACK);
    assign bus.o_BUS_RDATA = rdata_q & {32{state_q == ACK}};
    assign o_IRQ           = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer -- directed self-checking bench for bus_timer.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bus_timer_if bus ();

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus.slave),
        .o_IRQ (irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.i_BUS_ADDR  = 32'b0;
        bus.i_BUS_WDATA = 32'b0;
        bus.i_BUS_WE    = 1'b0;
        bus.i_BUS_RE    = 1'b0;
        bus.i_BUS_HB    = 2'b00;
        bus.i_BUS_REQ   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_bus();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // One bus transaction; returns the granted read data, the IRQ level seen
    // in the grant cycle and whether a grant arrived at all.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic we, input logic re, input logic [1:0] hb,
                             output logic [31:0] rd, output logic irq_g, output bit got);
        got   = 1'b0;
        rd    = 32'b0;
        irq_g = 1'b0;
        bus.i_BUS_ADDR  = addr;
        bus.i_BUS_WDATA = wdata;
        bus.i_BUS_WE    = we;
        bus.i_BUS_RE    = re;
        bus.i_BUS_HB    = hb;
        bus.i_BUS_REQ   = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (bus.o_BUS_GNT === 1'b1) begin
                got   = 1'b1;
                rd    = bus.o_BUS_RDATA;
                irq_g = irq;
            end
        end
        idle_bus();
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL access_timeout addr=%h: got no grant, required grant within 8 cycles", addr);
        end
        step();
        $display("ACCESS addr=%h we=%0d re=%0d hb=%0d wdata=%h rdata=%h gnt=%0d",
                 addr, we, re, hb, wdata, rd, got);
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        ig;
        bit          got;
        do_access(addr, data, 1'b1, 1'b0, 2'b10, rd, ig, got);
    endtask

    task automatic rd32(input logic [31:0] addr, output logic [31:0] rd);
        logic ig;
        bit   got;
        do_access(addr, 32'b0, 1'b0, 1'b1, 2'b10, rd, ig, got);
    endtask

    task automatic test_reset();
        idle_bus();
        rst = 1'b1;
        bus.i_BUS_ADDR = BASE + 32'h8;
        bus.i_BUS_RE   = 1'b1;
        bus.i_BUS_HB   = 2'b10;
        bus.i_BUS_REQ  = 1'b1;
        step();
        step();
        checks++;
        if (bus.o_BUS_GNT !== 1'b0 || bus.o_BUS_RDATA !== 32'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b rdata=%h irq=%b, required 0/0/0",
                     bus.o_BUS_GNT, bus.o_BUS_RDATA, irq);
        end
        idle_bus();
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_after_reset();
        apply_reset();
        bus.i_BUS_ADDR = BASE + 32'hC;
        bus.i_BUS_RE   = 1'b1;
        bus.i_BUS_HB   = 2'b10;
        bus.i_BUS_REQ  = 1'b1;
        checks++;
        if (bus.o_BUS_GNT !== 1'b0) begin
            failures++;
            $display("FAIL first_cycle_gnt: got %b required 0", bus.o_BUS_GNT);
        end
        step();
        checks++;
        if (bus.o_BUS_GNT !== 1'b1 || bus.o_BUS_RDATA !== 32'b0) begin
            failures++;
            $display("FAIL compare_read_ack: gnt=%b rdata=%h required 1/00000000",
                     bus.o_BUS_GNT, bus.o_BUS_RDATA);
        end
        step();
        checks++;
        if (bus.o_BUS_GNT !== 1'b0 || bus.o_BUS_RDATA !== 32'b0) begin
            failures++;
            $display("FAIL gnt_one_cycle: gnt=%b rdata=%h required 0/00000000 with REQ held",
                     bus.o_BUS_GNT, bus.o_BUS_RDATA);
        end
        idle_bus();
        step();
    endtask

    task automatic test_timer_match();
        logic [31:0] rd;
        logic        ig;
        bit          got;
        apply_reset();
        wr32(BASE + 32'hC, 32'd3);
        wr32(BASE + 32'h4, 32'd0);
        wr32(BASE + 32'h0, 32'h7);
        // COUNT is 1 here; it reaches 3 and wraps to 0 on the third edge.
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irq !== 1'b0) begin
                failures++;
                $display("FAIL irq_early step %0d: got %b required 0", k, irq);
            end
            step();
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_on_match: got %b required 1", irq);
        end
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL count_reloaded: got %h required 00000000", rd);
        end
        do_access(BASE + 32'h10, 32'h1, 1'b1, 1'b0, 2'b10, rd, ig, got);
        checks++;
        if (ig !== 1'b0) begin
            failures++;
            $display("FAIL w1c_clears_irq: got %b required 0", ig);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL match_repeats: got %b required 1", irq);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        logic        ig;
        bit          got;
        apply_reset();
        do_access(BASE + 32'h9, 32'h0000_AB00, 1'b1, 1'b0, 2'b00, rd, ig, got);
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h0000_AB00) begin
            failures++;
            $display("FAIL byte_write: got %h required 0000ab00", rd);
        end
        do_access(BASE + 32'h9, 32'h1234_5678, 1'b1, 1'b0, 2'b01, rd, ig, got);
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_half_gnt: got %b required 1", got);
        end
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h0000_AB00) begin
            failures++;
            $display("FAIL misaligned_half_dropped: got %h required 0000ab00", rd);
        end
        do_access(BASE + 32'hA, 32'hCDEF_0000, 1'b1, 1'b0, 2'b01, rd, ig, got);
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'hCDEF_AB00) begin
            failures++;
            $display("FAIL upper_half_write: got %h required cdefab00", rd);
        end
        do_access(BASE + 32'hE, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, rd, ig, got);
        rd32(BASE + 32'hC, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL misaligned_word_dropped: got %h required 00000000", rd);
        end
        wr32(BASE + 32'h14, 32'hFFFF_FFFF);
        rd32(BASE + 32'h14, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL unused_offset: got %h required 00000000", rd);
        end
        wr32(BASE + 32'h0, 32'hFFFF_FFF8);
        rd32(BASE + 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL ctrl_unused_bits: got %h required 00000000", rd);
        end
        wr32(BASE + 32'h4, 32'hFFFF_1234);
        rd32(BASE + 32'h4, rd);
        checks++;
        if (rd !== 32'h0000_1234) begin
            failures++;
            $display("FAIL prescale_width: got %h required 00001234", rd);
        end
    endtask

    task automatic test_prescale_wrap();
        logic [31:0] rd;
        apply_reset();
        wr32(BASE + 32'h8, 32'hFFFF_FFFF);
        wr32(BASE + 32'h4, 32'd2);
        wr32(BASE + 32'h0, 32'h3);
        // Ticks on the 3rd edge (wrap to 0) and 6th edge (match at COUNT==0).
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (irq !== (k == 6)) begin
                failures++;
                $display("FAIL wrap_irq step %0d: got %b required %b", k, irq, (k == 6));
            end
            if (k < 6) step();
        end
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'd1) begin
            failures++;
            $display("FAIL count_after_match: got %h required 00000001", rd);
        end
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'd1) begin
            failures++;
            $display("FAIL prescale_hold: got %h required 00000001", rd);
        end
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'd2) begin
            failures++;
            $display("FAIL prescale_next_tick: got %h required 00000002", rd);
        end
    endtask

    task automatic test_collisions();
        logic [31:0] rd;
        logic        ig;
        bit          got;
        apply_reset();
        wr32(BASE + 32'hC, 32'h50);
        wr32(BASE + 32'h4, 32'd0);
        wr32(BASE + 32'h0, 32'h1);
        wr32(BASE + 32'h8, 32'h100);   // commits on a tick edge
        rd32(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h101) begin
            failures++;
            $display("FAIL count_write_beats_tick: got %h required 00000101", rd);
        end
        wr32(BASE + 32'h0, 32'h0);
        wr32(BASE + 32'h8, 32'h10);
        wr32(BASE + 32'hC, 32'h11);
        wr32(BASE + 32'h0, 32'h1);
        // COUNT is 0x11 now; the W1C commits on the matching tick.
        do_access(BASE + 32'h10, 32'h1, 1'b1, 1'b0, 2'b10, rd, ig, got);
        rd32(BASE + 32'h10, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL match_beats_w1c: got %h required 00000001", rd);
        end
        wr32(BASE + 32'h10, 32'h1);
        rd32(BASE + 32'h10, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL w1c_plain: got %h required 00000000", rd);
        end
    endtask

    task automatic test_no_select();
        logic [31:0] rd;
        apply_reset();
        bus.i_BUS_ADDR = BASE + 32'h20;
        bus.i_BUS_RE   = 1'b1;
        bus.i_BUS_HB   = 2'b10;
        bus.i_BUS_REQ  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.o_BUS_GNT !== 1'b0 || bus.o_BUS_RDATA !== 32'b0) begin
                failures++;
                $display("FAIL out_of_window cycle %0d: gnt=%b rdata=%h required 0/00000000",
                         k, bus.o_BUS_GNT, bus.o_BUS_RDATA);
            end
        end
        idle_bus();
        bus.i_BUS_ADDR = BASE;
        bus.i_BUS_REQ  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.o_BUS_GNT !== 1'b0 || bus.o_BUS_RDATA !== 32'b0) begin
                failures++;
                $display("FAIL no_strobe cycle %0d: gnt=%b rdata=%h required 0/00000000",
                         k, bus.o_BUS_GNT, bus.o_BUS_RDATA);
            end
        end
        idle_bus();
        step();
        wr32(BASE + 32'hC, 32'h55);
        wr32(BASE + 32'h0, 32'h6);
        bus.i_BUS_ADDR  = BASE + 32'h4;
        bus.i_BUS_WDATA = 32'h33;
        bus.i_BUS_WE    = 1'b1;
        bus.i_BUS_HB    = 2'b10;
        bus.i_BUS_REQ   = 1'b1;
        step();
        checks++;
        if (bus.o_BUS_GNT !== 1'b1) begin
            failures++;
            $display("FAIL ack_before_reset: gnt=%b required 1", bus.o_BUS_GNT);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.o_BUS_GNT !== 1'b0 || bus.o_BUS_RDATA !== 32'b0) begin
            failures++;
            $display("FAIL reset_aborts_ack: gnt=%b rdata=%h required 0/00000000",
                     bus.o_BUS_GNT, bus.o_BUS_RDATA);
        end
        rst = 1'b0;
        idle_bus();
        step();
        for (int k = 0; k < 5; k++) begin
            rd32(BASE + 32'(k * 4), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL post_reset_reg offset %0d: got %h required 00000000", k * 4, rd);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_bus();
        rst = 1'b1;
        step();
        test_reset();
        test_read_after_reset();
        test_timer_match();
        test_byte_half();
        test_prescale_wrap();
        test_collisions();
        test_no_select();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
